exception_commit: RTL

EXCEPTION_COMMIT -- requirements
Module: exception_commit

---
 rtl/exception_commit_pkg.sv | 54 +++++
 rtl/exception_commit_cp0_timer.sv | 55 +++++
 rtl/exception_commit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/exception_commit_pkg.sv
// Shared CPU defines: CP0 register numbers, exception codes, the exception vector
// and the fixed-priority exception selector used at the MEM commit point.
package exception_commit_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  localparam logic [4:0] EXC_TR   = 5'h0D;

  typedef enum logic [1:0] {
    BADV_KEEP,
    BADV_PC,
    BADV_ADDR
  } badv_src_e;

  typedef struct packed {
    logic       taken;
    logic [4:0] code;
    badv_src_e  badv_src;
  } exc_decision_t;

  // exc bit order is {adel_if, ri, ov, trap, sys, bp, adel_d, ades_d}
  function automatic exc_decision_t prioritize_exc(input logic int_req, input logic [7:0] exc);
    exc_decision_t d;
    d.taken    = 1'b1;
    d.code     = EXC_INT;
    d.badv_src = BADV_KEEP;
    if (int_req)     d.code = EXC_INT;
    else if (exc[7]) begin d.code = EXC_ADEL; d.badv_src = BADV_PC; end
    else if (exc[6]) d.code = EXC_RI;
    else if (exc[5]) d.code = EXC_OV;
    else if (exc[4]) d.code = EXC_TR;
    else if (exc[3]) d.code = EXC_SYS;
    else if (exc[2]) d.code = EXC_BP;
    else if (exc[1]) begin d.code = EXC_ADEL; d.badv_src = BADV_ADDR; end
    else if (exc[0]) begin d.code = EXC_ADES; d.badv_src = BADV_ADDR; end
    else             d.taken = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/exception_commit_cp0_timer.sv
// CP0 Count/Compare pair: Count advances every second cycle, TI latches on a
// Count==Compare match until Compare is rewritten.
module cp0_timer
  import exception_commit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        toggle_q, toggle_d;
  logic        ti_q, ti_d;

  // Software writes take precedence over the free-running increment and the match.
  always_comb begin
    toggle_d  = ~toggle_q;
    count_d   = toggle_q ? count_q + 32'd1 : count_q;
    compare_d = compare_q;
    ti_d      = ti_q | (count_q == compare_q);
    if (count_we) begin
      count_d  = wdata;
      toggle_d = 1'b0;
    end
    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q   <= '0;
      compare_q <= '0;
      toggle_q  <= 1'b0;
      ti_q      <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= toggle_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/exception_commit.sv
// MEM-stage exception/ERET commit point with the CP0 register file: decides the
// flush and redirect target and updates Status/Cause/EPC/BadVAddr on commit.
module exception_commit
  import exception_commit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delayslot,
  input  logic [7:0]  mem_exc,
  input  logic [31:0] mem_badvaddr,
  input  logic        mem_eret,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  output logic        flush,
  output logic [31:0] redirect_pc
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [7:2]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic          commit, int_req, exc_take, eret_take, mtc0;
  logic [7:0]    cause_ip;
  exc_decision_t dec;
  logic [31:0]   timer_count, timer_compare;
  logic          timer_ti;
  logic [31:0]   status_rd, cause_rd;

  assign commit    = mem_valid & ~mem_stall;
  assign cause_ip  = {ip_hw_q, ip_sw_q};
  assign int_req   = ie_q & ~exl_q & |(cause_ip & im_q);
  assign dec       = prioritize_exc(int_req, mem_exc);
  assign exc_take  = commit & dec.taken;
  assign eret_take = commit & mem_eret & ~dec.taken;
  assign mtc0      = commit & cp0_we & ~dec.taken;

  assign flush       = resetn & (exc_take | eret_take);
  assign redirect_pc = !resetn   ? 32'h0 :
                       exc_take  ? EXC_VECTOR :
                       eret_take ? epc_q : 32'h0;

  cp0_timer u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .count_we   (mtc0 && (cp0_waddr == CP0_COUNT)),
    .compare_we (mtc0 && (cp0_waddr == CP0_COMPARE)),
    .wdata      (cp0_wdata),
    .count      (timer_count),
    .compare    (timer_compare),
    .ti         (timer_ti)
  );

  // Nested exceptions (EXL already set) keep the original EPC and BD.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_hw_d    = {hw_int[5] | timer_ti, hw_int[4:0]};
    ip_sw_d    = ip_sw_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    if (mtc0) begin
      case (cp0_waddr)
        CP0_STATUS: begin
          im_d  = cp0_wdata[15:8];
          exl_d = cp0_wdata[1];
          ie_d  = cp0_wdata[0];
        end
        CP0_CAUSE: ip_sw_d = cp0_wdata[9:8];
        CP0_EPC:   epc_d   = cp0_wdata;
        default: ;
      endcase
    end
    if (eret_take) exl_d = 1'b0;
    if (exc_take) begin
      exccode_d = dec.code;
      exl_d     = 1'b1;
      if (!exl_q) begin
        bd_d  = mem_in_delayslot;
        epc_d = mem_in_delayslot ? mem_pc - 32'd4 : mem_pc;
      end
      case (dec.badv_src)
        BADV_PC:   badvaddr_d = mem_pc;
        BADV_ADDR: badvaddr_d = mem_badvaddr;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // BEV (bit 22) is hardwired to 1.
  assign status_rd = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd  = {bd_q, timer_ti, 14'b0, cause_ip, 1'b0, exccode_q, 2'b0};

  always_comb begin
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = timer_count;
      CP0_COMPARE:  cp0_rdata = timer_compare;
      CP0_STATUS:   cp0_rdata = status_rd;
      CP0_CAUSE:    cp0_rdata = cause_rd;
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = 32'h0;
    endcase
  end

endmodule
